ccff_bitstream_loader: RTL
==========================

// Module: ccff_bitstream_loader
// PURPOSE
//  Upstream driver of the configuration-chain head of a logic tile (ble6: 64 LUT6 bits + 3 output-mux bits).
//  Accepts bitstream words over a valid/ready stream and serialises them LSB-first onto ccff_head.
//  Each shifted bit is qualified by ccff_en, the enable to the prog_clk gate of the chain.
//  Stops after exactly CHAIN_LEN bits and pulses done.
// PARAMETERS
//  WORD_W     32   bits per input word
//  CHAIN_LEN  67   configuration bits in the downstream chain (>=1)
//  CNT_W      $clog2(CHAIN_LEN+1)  bit-counter width (derived, localparam)
// PORTS
//  prog_clk   in   1        configuration clock
//  pReset_n   in   1        asynchronous reset, active-low
//  start      in   1        begin a load; sampled only in IDLE
//  abort      in   1        synchronous abandon of a load in progress
//  s_valid    in   1        input word valid
//  s_data     in   WORD_W   input word, bit 0 shifted first
//  s_ready    out  1        loader accepts word this cycle
//  ccff_head  out  1        serial bit to chain head
//  ccff_en    out  1        chain shift enable (1 = chain advances this prog_clk)
//  ccff_tail  in   1        chain tail, used only with CCFF_READBACK_EN
//  busy       out  1        state != IDLE
//  done       out  1        one-cycle pulse, load complete
// BEHAVIOUR
//  Reset is asynchronous, active-low; ports prog_clk and pReset_n. Reset state: IDLE.
//  Reset values: s_ready=0, ccff_head=0, ccff_en=0, busy=0, done=0, bit_cnt=0, sreg=0.
//  All outputs are functions of flops only; no combinational input->output path.
//  FSM: IDLE -> FETCH -> SHIFT -> {FETCH | DONE} -> IDLE.
//   IDLE:  start=1 -> FETCH, bit_cnt<=0. Otherwise hold.
//   FETCH: s_ready=1, ccff_en=0 (chain holds).
//          s_valid -> sreg<=s_data, word_idx<=0, go SHIFT.
//   SHIFT: ccff_en=1, ccff_head=sreg[0]; sreg>>=1, word_idx++, bit_cnt++ each cycle.
//          bit_cnt==CHAIN_LEN-1 -> DONE; the unused bits of the final word are discarded.
//          else word_idx==WORD_W-1 -> FETCH.
//   DONE:  done=1 for exactly one cycle -> IDLE.
//  Latency: word accepted at cycle t gives its first bit with ccff_en=1 at cycle t+1.
//   With s_valid held high: ceil(CHAIN_LEN/WORD_W) fetch cycles + CHAIN_LEN shift cycles, then done.
//   Defaults: 3 + 67 = 70 cycles from the first FETCH to the done cycle.
//  start while busy: ignored.
//  abort (any non-IDLE state): next state IDLE, ccff_en=0 from the following cycle, no done.
//   The chain content is partial/undefined and must be reloaded.
//  abort takes priority over a simultaneous s_valid, shift or DONE transition.
//  s_valid in IDLE/SHIFT/DONE: not accepted, s_ready=0; the word is held by the producer.
//  pReset_n asserted mid-load: immediate IDLE, ccff_en=0; the chain keeps its partial contents.
//  bit_cnt never exceeds CHAIN_LEN; no wrap.
// CONFIGURATION
//  CCFF_READBACK_EN defined:
//   - Every SHIFT cycle, ccff_tail is shifted into a WORD_W capture register, LSB first.
//   - Extra outputs: rb_valid (1), rb_data (WORD_W).
//   - rb_valid pulses for one cycle per full word captured, and at DONE for a partial word, zero-padded in the MSBs.
//   - No backpressure. Reset: rb_valid=0, rb_data=0.
//   - Gives the previous chain contents, for bitstream verification.
//  CCFF_READBACK_EN undefined: ccff_tail unconnected internally; no rb_* ports; no capture logic.
// STRUCTURE
//  Package ccff_loader_pkg contains:
//   - the state enum ccff_ld_state_e {IDLE, FETCH, SHIFT, DONE};
//   - function cnt_w(len) returning $clog2(len+1).
//  Sub-module ccff_word_serializer (WORD_W): load/shift controls, sreg, word_idx, last_bit flag, ser_out.
//  The FSM, bit_cnt and readback logic stay in the top module.
// TESTING
//  1. Defaults; start; s_valid held with words 0xA5A5_A5A5, 0x0F0F_0F0F, 0x0000_0005.
//     -> 67 ccff_en cycles; head sequence = LSB-first bits; done at cycle 70; 29 trailing bits dropped.
//  2. s_valid deasserted 5 cycles before word 2.
//     -> ccff_en=0 during the gap; chain model content identical to scenario 1; done 5 cycles later.
//  3. abort at shift bit 40.
//     -> IDLE next cycle, ccff_en=0, no done, busy=0; a new start then loads all 67 bits correctly.
//  4. pReset_n low at bit 20, then released; start again.
//     -> all outputs at reset values while low; full load completes normally.
//  5. start pulsed while busy; CHAIN_LEN=32 with WORD_W=32.
//     -> ignored; exactly 1 fetch + 32 shifts, done at cycle 33.
//  6. CCFF_READBACK_EN: chain model preloaded with 67 known bits.
//     -> rb_valid x3; rb_data = preload, LSB first; 3rd word = 3 bits zero-padded.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared types and helpers for the configuration-chain loader
// Purpose: loader FSM state encoding and the bit-counter width helper.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_ld_state_e;

  // Width needed to count from 0 up to and including len.
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// rtl/ccff_word_serializer.sv - one-word parallel-to-serial shifter, LSB first
// Purpose: holds the word being shifted onto the chain and tracks position within it.
// Macro: CCFF_READBACK_EN adds o_word_idx for the readback capture in the top.
// Ports:
//   prog_clk, pReset_n  clock, asynchronous active-low reset
//   i_load              capture i_data, restart word position
//   i_shift             shift right by one, advance word position
//   i_data              word to serialise
//   o_ser_out           bit currently presented (sreg[0])
//   o_last_bit          current bit is the last bit of the word
//   o_word_idx          current bit position (readback builds only)
module ccff_word_serializer #(
  parameter int WORD_W = 32,
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_ser_out,
  output logic              o_last_bit
`ifdef CCFF_READBACK_EN
  ,
  output logic [IDX_W-1:0]  o_word_idx
`endif
);

  logic [WORD_W-1:0] r_sreg;
  logic [IDX_W-1:0]  r_word_idx;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_sreg     <= '0;
      r_word_idx <= '0;
    end else if (i_load) begin
      r_sreg     <= i_data;
      r_word_idx <= '0;
    end else if (i_shift) begin
      r_sreg     <= r_sreg >> 1;
      r_word_idx <= r_word_idx + 1'b1;
    end
  end

  assign o_ser_out  = r_sreg[0];
  assign o_last_bit = (r_word_idx == IDX_W'(WORD_W - 1));
`ifdef CCFF_READBACK_EN
  assign o_word_idx = r_word_idx;
`endif

endmodule

// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - streams bitstream words LSB-first into a configuration chain head
// Purpose: FETCH/SHIFT loader that stops after exactly CHAIN_LEN bits and pulses done.
// Macro: CCFF_READBACK_EN captures ccff_tail during shifting and emits rb_valid/rb_data.
// Ports:
//   prog_clk, pReset_n    clock, asynchronous active-low reset
//   start, abort          begin a load (IDLE only) / abandon a load in progress
//   s_valid/s_data/s_ready  input word stream, bit 0 shifted first
//   ccff_head, ccff_en    serial bit and shift enable toward the chain
//   ccff_tail             chain tail (readback builds only)
//   busy, done            not idle / one-cycle completion pulse
//   rb_valid, rb_data     captured previous chain contents (readback builds only)
module ccff_bitstream_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 67
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
`endif
);
  import ccff_loader_pkg::*;

  localparam int CNT_W = cnt_w(CHAIN_LEN);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  ccff_ld_state_e   r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_s_ready;
  logic             r_ccff_en;
  logic             r_busy;
  logic             r_done;

  logic w_load;
  logic w_shift;
  logic w_ser_out;
  logic w_last_bit;
  logic w_final_bit;

  // abort outranks any transfer that would otherwise happen this cycle
  assign w_load      = (r_state == FETCH) && s_valid && !abort;
  assign w_shift     = (r_state == SHIFT) && !abort;
  assign w_final_bit = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));

`ifdef CCFF_READBACK_EN
  logic [IDX_W-1:0] w_word_idx;
`endif

  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .prog_clk   (prog_clk),
    .pReset_n   (pReset_n),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (s_data),
    .o_ser_out  (w_ser_out),
    .o_last_bit (w_last_bit)
`ifdef CCFF_READBACK_EN
    ,
    .o_word_idx (w_word_idx)
`endif
  );

  // Outputs are set alongside the state they belong to, so they are pure flops.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_s_ready <= 1'b0;
      r_ccff_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (abort && (r_state != IDLE)) begin
      r_state   <= IDLE;
      r_s_ready <= 1'b0;
      r_ccff_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= FETCH;
            r_bit_cnt <= '0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        FETCH: begin
          if (s_valid) begin
            r_state   <= SHIFT;
            r_s_ready <= 1'b0;
            r_ccff_en <= 1'b1;
          end
        end
        SHIFT: begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          // chain full wins over word boundary: leftover word bits are dropped
          if (w_final_bit) begin
            r_state   <= DONE;
            r_ccff_en <= 1'b0;
            r_done    <= 1'b1;
          end else if (w_last_bit) begin
            r_state   <= FETCH;
            r_ccff_en <= 1'b0;
            r_s_ready <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign ccff_en   = r_ccff_en;
  assign ccff_head = w_ser_out;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] r_rb_cap;
  logic [WORD_W-1:0] r_rb_data;
  logic              r_rb_valid;
  logic [WORD_W-1:0] w_rb_next;

  // tail bit lands at the same position its replacement takes in the word
  assign w_rb_next = r_rb_cap | (WORD_W'(ccff_tail) << w_word_idx);

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_rb_cap   <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (r_state == IDLE) begin
        r_rb_cap <= '0;
      end else if (w_shift) begin
        if (w_last_bit || w_final_bit) begin
          r_rb_data  <= w_rb_next;
          r_rb_valid <= 1'b1;
          r_rb_cap   <= '0;
        end else begin
          r_rb_cap <= w_rb_next;
        end
      end
    end
  end

  assign rb_valid = r_rb_valid;
  assign rb_data  = r_rb_data;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif

endmodule
